// File: rtl/gst_snd_pkg.sv
// Shared definitions for the DMA sound engine.
//   snd_fmt_e / FMT_*   : sample format codes (fmt port)
//   snd_rate_e / RATE_* : playback rate codes (rate port)
//   snd_midpoint()      : unsigned silence level for a given output width
package gst_snd_pkg;

  localparam logic [1:0] FMT_STEREO8  = 2'd0;
  localparam logic [1:0] FMT_MONO8    = 2'd1;
  localparam logic [1:0] FMT_STEREO16 = 2'd2;
  localparam logic [1:0] FMT_RSVD     = 2'd3;

  localparam logic [1:0] RATE_6K25 = 2'd0;
  localparam logic [1:0] RATE_12K5 = 2'd1;
  localparam logic [1:0] RATE_25K  = 2'd2;
  localparam logic [1:0] RATE_50K  = 2'd3;

  typedef enum logic [1:0] {
    SF_STEREO8  = FMT_STEREO8,
    SF_MONO8    = FMT_MONO8,
    SF_STEREO16 = FMT_STEREO16,
    SF_RSVD     = FMT_RSVD
  } snd_fmt_e;

  typedef enum logic [1:0] {
    SR_6K25 = RATE_6K25,
    SR_12K5 = RATE_12K5,
    SR_25K  = RATE_25K,
    SR_50K  = RATE_50K
  } snd_rate_e;

  // Unsigned midpoint (silence) for an output of width w, 1..16 bits.
  function automatic logic [15:0] snd_midpoint(input int unsigned w);
    return 16'h0001 << (w - 1);
  endfunction

endpackage

// File: rtl/gst_snd_fifo.sv
// Counted word FIFO for the DMA sound engine.
//   clk32, res      : clock, synchronous active-high reset
//   flush           : empties the FIFO; a same-cycle push is discarded
//   push, din       : write one word; dropped when full
//   pop_n           : number of words to retire this cycle (0, 1 or 2)
//   head, head1     : words at the read pointer and the one after it
//   level           : words currently stored (0..2**AW)
module gst_snd_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic          clk32,
  input  logic          res,
  input  logic          flush,
  input  logic          push,
  input  logic [15:0]   din,
  input  logic [1:0]    pop_n,
  output logic [15:0]   head,
  output logic [15:0]   head1,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;

  assign do_push = push && !flush && !res && (level != (AW+1)'(DEPTH));

  always_ff @(posedge clk32) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk32) begin
    if (res || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_n);
      level  <= level + (AW+1)'(do_push) - (AW+1)'(pop_n);
    end
  end

  assign head  = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/gst_dma_sound.sv
// DMA sound playback engine: buffers DMA words captured on SLOAD_N falling
// edges, paces them out at the programmed rate and presents unsigned L/R
// samples.
//   clk32, res        : 32 MHz clock, synchronous active-high reset
//   fmt               : 0 stereo8, 1 mono8, 2 stereo16, 3 treated as stereo8
//   rate              : 0 6.25k, 1 12.5k, 2 25k, 3 50 kHz
//   flush             : empty FIFO, restart sequencing, silence outputs
//   SLOAD_N, MDIN     : DMA load strobe and data word
//   SREQ              : DMA request, high while at least two words free
//   fifo_level        : words buffered
//   sample_tick       : one-cycle strobe, new sample pair on audio_*
//   underrun          : sticky starvation flag
//   audio_left/right  : unsigned samples, OUT_W bits
// Optional feature macro: SND_UNDERRUN_EN. When defined, starvation at a
// sample slot sets underrun and silences the outputs; otherwise underrun is
// 0 and the outputs hold the last sample.
module gst_dma_sound
  import gst_snd_pkg::*;
#(
  parameter int unsigned FIFO_AW  = 3,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned BASE_DIV = 640
) (
  input  logic               clk32,
  input  logic               res,
  input  logic [1:0]         fmt,
  input  logic [1:0]         rate,
  input  logic               flush,
  input  logic               SLOAD_N,
  input  logic [15:0]        MDIN,
  output logic               SREQ,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               sample_tick,
  output logic               underrun,
  output logic [OUT_W-1:0]   audio_left,
  output logic [OUT_W-1:0]   audio_right
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [OUT_W-1:0] MID = OUT_W'(snd_midpoint(OUT_W));

  // Signed 16-bit (8-bit samples sit in the upper byte) to unsigned OUT_W.
  function automatic logic [OUT_W-1:0] to_out(input logic [15:0] v);
    logic [15:0] u;
    u = v ^ 16'h8000;
    return u[15 -: OUT_W];
  endfunction

  // ---------------- load strobe edge detect ----------------
  logic sload_d;
  logic push;

  always_ff @(posedge clk32) begin
    if (res) sload_d <= 1'b1;
    else     sload_d <= SLOAD_N;
  end

  assign push = sload_d & ~SLOAD_N;

  // ---------------- FIFO ----------------
  logic [15:0] head;
  logic [15:0] head1;
  logic [1:0]  pop_n;

  gst_snd_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk32 (clk32),
    .res   (res),
    .flush (flush),
    .push  (push),
    .din   (MDIN),
    .pop_n (pop_n),
    .head  (head),
    .head1 (head1),
    .level (fifo_level)
  );

  assign SREQ = (fifo_level < (FIFO_AW+1)'(DEPTH - 1));

  // ---------------- rate generator ----------------
  logic [CW-1:0] base_cnt;
  logic          base_en;
  logic [2:0]    sub_cnt;
  logic          rate_hit;
  logic          aclk_en;

  assign base_en = (base_cnt == '0);

  always_comb begin
    rate_hit = 1'b0;
    case (snd_rate_e'(rate))
      SR_50K:  rate_hit = 1'b1;
      SR_25K:  rate_hit = (sub_cnt[0] == 1'b0);
      SR_12K5: rate_hit = (sub_cnt[1:0] == 2'b00);
      default: rate_hit = (sub_cnt == 3'b000);
    endcase
  end

  // Counters free-run from reset; flush deliberately leaves them alone.
  always_ff @(posedge clk32) begin
    if (res) begin
      base_cnt <= '0;
      sub_cnt  <= '0;
      aclk_en  <= 1'b0;
    end else begin
      base_cnt <= (base_cnt == CW'(BASE_DIV - 1)) ? '0 : base_cnt + CW'(1);
      if (base_en) sub_cnt <= sub_cnt + 3'd1;
      aclk_en  <= base_en & rate_hit;
    end
  end

  // ---------------- format sequencer ----------------
  snd_fmt_e         fmt_q;
  logic             phase;
  logic             phase_n;
  logic             cur_phase;
  logic             upd;
  logic [OUT_W-1:0] l_n;
  logic [OUT_W-1:0] r_n;
  logic [7:0]       mono_b;
`ifdef SND_UNDERRUN_EN
  logic             starve;
`endif

  always_comb begin
    pop_n     = 2'd0;
    upd       = 1'b0;
    l_n       = audio_left;
    r_n       = audio_right;
    phase_n   = phase;
    mono_b    = 8'h00;
    // A format change restarts mono byte order from the high byte.
    cur_phase = (snd_fmt_e'(fmt) != fmt_q) ? 1'b0 : phase;
`ifdef SND_UNDERRUN_EN
    starve    = 1'b0;
`endif
    if (aclk_en) begin
      phase_n = cur_phase;
      case (snd_fmt_e'(fmt))
        SF_MONO8: begin
          if (fifo_level != '0) begin
            mono_b  = cur_phase ? head[7:0] : head[15:8];
            l_n     = to_out({mono_b, 8'h00});
            r_n     = to_out({mono_b, 8'h00});
            phase_n = ~cur_phase;
            pop_n   = cur_phase ? 2'd1 : 2'd0;
            upd     = 1'b1;
          end
`ifdef SND_UNDERRUN_EN
          else starve = 1'b1;
`endif
        end
        SF_STEREO16: begin
          if (fifo_level >= (FIFO_AW+1)'(2)) begin
            l_n   = to_out(head);
            r_n   = to_out(head1);
            pop_n = 2'd2;
            upd   = 1'b1;
          end
`ifdef SND_UNDERRUN_EN
          else starve = 1'b1;
`endif
        end
        default: begin
          if (fifo_level != '0) begin
            l_n   = to_out({head[15:8], 8'h00});
            r_n   = to_out({head[7:0], 8'h00});
            pop_n = 2'd1;
            upd   = 1'b1;
          end
`ifdef SND_UNDERRUN_EN
          else starve = 1'b1;
`endif
        end
      endcase
    end
  end

  // ---------------- output registers ----------------
`ifdef SND_UNDERRUN_EN
  logic underrun_q;
  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

  always_ff @(posedge clk32) begin
    if (res) begin
      fmt_q       <= SF_STEREO8;
      phase       <= 1'b0;
      audio_left  <= MID;
      audio_right <= MID;
      sample_tick <= 1'b0;
`ifdef SND_UNDERRUN_EN
      underrun_q  <= 1'b0;
`endif
    end else if (flush) begin
      phase       <= 1'b0;
      audio_left  <= MID;
      audio_right <= MID;
      sample_tick <= 1'b0;
`ifdef SND_UNDERRUN_EN
      underrun_q  <= 1'b0;
`endif
    end else begin
      if (aclk_en) fmt_q <= snd_fmt_e'(fmt);
      phase       <= phase_n;
      sample_tick <= upd;
      if (upd) begin
        audio_left  <= l_n;
        audio_right <= r_n;
      end
`ifdef SND_UNDERRUN_EN
      if (starve) begin
        underrun_q  <= 1'b1;
        audio_left  <= MID;
        audio_right <= MID;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gst_dma_sound.sv
module tb_gst_dma_sound;

  localparam int unsigned AW    = 3;
  localparam int unsigned OW    = 16;
  localparam int unsigned BDIV  = 64;
  localparam int unsigned DEPTH = 8;

  logic        clk32 = 1'b0;
  logic        res = 1'b1;
  logic [1:0]  fmt = 2'd0;
  logic [1:0]  rate = 2'd3;
  logic        flush = 1'b0;
  logic        SLOAD_N = 1'b1;
  logic [15:0] MDIN = 16'h0000;
  logic        SREQ;
  logic [AW:0] fifo_level;
  logic        sample_tick;
  logic        underrun;
  logic [OW-1:0] audio_left;
  logic [OW-1:0] audio_right;

  always #5 clk32 = ~clk32;

  gst_dma_sound #(.FIFO_AW(AW), .OUT_W(OW), .BASE_DIV(BDIV)) dut (
    .clk32       (clk32),
    .res         (res),
    .fmt         (fmt),
    .rate        (rate),
    .flush       (flush),
    .SLOAD_N     (SLOAD_N),
    .MDIN        (MDIN),
    .SREQ        (SREQ),
    .fifo_level  (fifo_level),
    .sample_tick (sample_tick),
    .underrun    (underrun),
    .audio_left  (audio_left),
    .audio_right (audio_right)
  );

`ifdef SND_UNDERRUN_EN
  localparam bit UND = 1'b1;
`else
  localparam bit UND = 1'b0;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Every tick seen on the outputs, {left,right}, in arrival order.
  logic [31:0] obs_q[$];
  always @(negedge clk32) if (sample_tick) obs_q.push_back({audio_left, audio_right});

  // Reference model: the buffered word stream and the mono byte position.
  logic [15:0] mq[$];
  bit          mphase;
  int          mfmt;
  logic [15:0] last_l, last_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] byte_out(input logic [7:0] b);
    return {b ^ 8'h80, 8'h00};
  endfunction

  // Next sample pair the spec rules derive from the buffered stream.
  task automatic model_next(output logic [15:0] el, output logic [15:0] er);
    logic [15:0] w0, w1;
    logic [7:0]  b;
    if (mfmt == 1) begin
      w0 = mq[0];
      b  = mphase ? w0[7:0] : w0[15:8];
      el = byte_out(b);
      er = el;
      if (mphase) void'(mq.pop_front());
      mphase = ~mphase;
    end else if (mfmt == 2) begin
      w0 = mq.pop_front();
      w1 = mq.pop_front();
      el = w0 ^ 16'h8000;
      er = w1 ^ 16'h8000;
    end else begin
      w0 = mq.pop_front();
      el = byte_out(w0[15:8]);
      er = byte_out(w0[7:0]);
    end
  endtask

  task automatic push(input logic [15:0] w);
    @(negedge clk32);
    MDIN = w;
    SLOAD_N = 1'b0;
    @(negedge clk32);
    SLOAD_N = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk32);
    res = 1'b1;
    repeat (3) @(negedge clk32);
    res = 1'b0;
  endtask

  task automatic do_flush(input int f, input int r);
    @(negedge clk32);
    fmt = 2'(f);
    rate = 2'(r);
    flush = 1'b1;
    @(negedge clk32);
    flush = 1'b0;
    obs_q.delete();
    mq.delete();
    mphase = 1'b0;
    mfmt = f;
  endtask

  function automatic int period(input int r);
    return int'(BDIV) * (r == 3 ? 1 : r == 2 ? 2 : r == 1 ? 4 : 8);
  endfunction

  // Play n words in format f at rate r, then compare all ticks and the
  // starved state against the model.
  task automatic run_phase(input string tag, input int f, input int r,
                           input logic [15:0] wl[$]);
    int ns;
    logic [15:0] el, er;
    do_flush(f, r);
    chk({tag, "_flush_und"}, 32'(underrun), 32'd0);
    foreach (wl[i]) begin
      mq.push_back(wl[i]);
      push(wl[i]);
    end
    ns = (f == 1) ? 2 * wl.size() : (f == 2) ? wl.size() / 2 : wl.size();
    repeat ((ns + 2) * period(r) + 20) @(negedge clk32);
    chk({tag, "_nticks"}, 32'(obs_q.size()), 32'(ns));
    for (int i = 0; i < ns; i++) begin
      model_next(el, er);
      last_l = el;
      last_r = er;
      if (i < obs_q.size()) chk({tag, "_sample"}, obs_q[i], {el, er});
    end
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_starve_und"}, 32'(underrun), 32'(UND));
    chk({tag, "_starve_out"}, {audio_left, audio_right},
        UND ? 32'h8000_8000 : {last_l, last_r});
  endtask

  logic [15:0] wl[$];
  bit          got;

  initial begin
    // ---- reset state ----
    do_reset();
    #1;
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_sreq", 32'(SREQ), 32'd1);
    chk("rst_audio", {audio_left, audio_right}, 32'h8000_8000);
    chk("rst_tick", 32'(sample_tick), 32'd0);
    chk("rst_und", 32'(underrun), 32'd0);

    // ---- fill: slowest rate, first slot passes empty right after reset ----
    rate = 2'd0;
    fmt = 2'd0;
    do_reset();
    repeat (4) @(negedge clk32);
    for (int i = 1; i <= 9; i++) begin
      push(16'($urandom));
      chk("fill_level", 32'(fifo_level), 32'(i > DEPTH ? DEPTH : i));
      chk("fill_sreq", 32'(SREQ), 32'(i < DEPTH - 1));
    end
    // reset mid-transfer with a strobe pending
    @(negedge clk32);
    SLOAD_N = 1'b0;
    res = 1'b1;
    @(negedge clk32);
    SLOAD_N = 1'b1;
    @(negedge clk32);
    res = 1'b0;
    #1;
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_und", 32'(underrun), 32'd0);

    // ---- flush with a simultaneous load edge ----
    do_flush(0, 0);
    push(16'h1234);
    push(16'h5678);
    @(negedge clk32);
    MDIN = 16'hABCD;
    SLOAD_N = 1'b0;
    flush = 1'b1;
    @(negedge clk32);
    flush = 1'b0;
    SLOAD_N = 1'b1;
    #1;
    chk("flushld_level", 32'(fifo_level), 32'd0);
    chk("flushld_sreq", 32'(SREQ), 32'd1);
    chk("flushld_audio", {audio_left, audio_right}, 32'h8000_8000);

    // ---- directed format cases ----
    wl = '{16'h7F80};
    run_phase("s8", 0, 3, wl);

    // mono8: word retained until its second byte has played
    do_flush(1, 3);
    push(16'h0010);
    got = 1'b0;
    for (int i = 0; i < 4 * int'(BDIV) && !got; i++) begin
      @(negedge clk32);
      got = (obs_q.size() == 1);
    end
    chk("m8_tick1_seen", 32'(got), 32'd1);
    chk("m8_level_mid", 32'(fifo_level), 32'd1);
    repeat (2 * BDIV) @(negedge clk32);
    chk("m8_nticks", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      chk("m8_s0", obs_q[0], 32'h8000_8000);
      chk("m8_s1", obs_q[1], 32'h9000_9000);
    end
    chk("m8_level_end", 32'(fifo_level), 32'd0);

    // stereo16: one word alone never produces a sample
    do_flush(2, 3);
    push(16'h0000);
    repeat (3 * BDIV) @(negedge clk32);
    chk("s16_lone_nticks", 32'(obs_q.size()), 32'd0);
    chk("s16_lone_level", 32'(fifo_level), 32'd1);
    push(16'hFFFF);
    repeat (2 * BDIV) @(negedge clk32);
    chk("s16_nticks", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) chk("s16_s0", obs_q[0], 32'h8000_7FFF);

    // ---- randomized phases ----
    for (int p = 0; p < 6; p++) begin
      int f, r, n;
      f = int'($urandom_range(0, 3));
      r = int'($urandom_range(2, 3));
      n = int'($urandom_range(1, 3));
      if (f == 2) n = 2 * n;
      wl.delete();
      for (int i = 0; i < n; i++) wl.push_back(16'($urandom));
      run_phase("rnd", f, r, wl);
    end

    // one run at the slowest rate
    wl = '{16'($urandom), 16'($urandom)};
    run_phase("slow", 0, 0, wl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
